ddr3_odt_lane_ctrl: RTL and testbench
=====================================

# ddr3_odt_lane_ctrl

Fabric-side controller for a parametrised group of DDR3 ODT / single-ended control-pin lanes. It sits between the DDR controller and the per-pin IOD output primitives (TX gearing + OE + dynamic delay line). Per channel, it converts an ODT assertion request (start phase, length in bit slots) into GEAR-wide TX_DATA/OE_DATA words every fabric cycle. It also runs a per-channel delay-line trim sequencer that drives LOAD/MOVE/DIRECTION to a requested tap and reports completion or out-of-range.

## Interface
Parameters:
- NUM_CH, 2, number of independent lanes
- GEAR, 4, bit slots per FAB_CLK (4 or 8)
- LEN_W, 6, width of ODT length field
- TAP_W, 7, width of tap target/current fields
- SETTLE, 4, idle cycles between LOAD and first MOVE (>=1)

Ports (per-channel fields packed, channel 0 at LSBs). One clock; reset is synchronous and active-high:
- FAB_CLK  in  1  fabric clock; all logic on rising edge
- TX_SYNC_RST  in  1  synchronous active-high reset
- CH_EN  in  NUM_CH  lane enable; gates OE_DATA
- ODT_REQ  in  NUM_CH  one-cycle assertion request
- ODT_PHASE  in  NUM_CH*log2(GEAR)  first slot asserted within first word
- ODT_LEN  in  NUM_CH*LEN_W  number of slots asserted
- ODT_BUSY  out  NUM_CH  burst in progress
- ODT_DROP  out  NUM_CH  one-cycle pulse: request ignored
- TX_DATA  out  NUM_CH*GEAR  serializer data; bit i = slot i, slot 0 sent first
- OE_DATA  out  NUM_CH*GEAR  output enable per slot
- TRIM_REQ  in  NUM_CH  start trim pulse
- TRIM_TARGET  in  NUM_CH*TAP_W  target tap
- TRIM_DONE  out  NUM_CH  one-cycle success pulse
- TRIM_ERR  out  NUM_CH  one-cycle out-of-range pulse
- TAP_CUR  out  NUM_CH*TAP_W  tracked tap count
- DELAY_LINE_LOAD / _MOVE / _DIRECTION  out  NUM_CH each  to IOD
- DELAY_LINE_OUT_OF_RANGE  in  NUM_CH  from IOD

## Operation
- Reset: all outputs 0, all FSMs IDLE, counters 0. OE_DATA lane = all-ones from the cycle after CH_EN is sampled high; all-zeros otherwise (registered).
- ODT generator (per channel, counter `rem` of LEN_W+1 bits):
  - ODT_REQ with ODT_BUSY=0 and ODT_LEN>0 is accepted. The next word sets slots ODT_PHASE..min(GEAR-1, PHASE+LEN-1). rem = LEN-(GEAR-PHASE), saturating at 0.
  - Each following cycle emits min(rem,GEAR) ones from slot 0 and decrements rem by GEAR (saturating). Otherwise TX_DATA=0.
  - ODT_BUSY is high in every cycle a nonzero word is presented.
  - ODT_REQ while BUSY, or with LEN=0 → ignored; ODT_DROP pulses the next cycle. An accepted request in the cycle after BUSY falls is legal (gapless burst not supported).
  - CH_EN=0 does not stop TX_DATA generation; it only masks OE.
- Trim FSM (per channel): IDLE → LOAD → SETTLE → STEP_HI ↔ STEP_LO → IDLE.
  - IDLE: TRIM_REQ latches target → LOAD.
  - LOAD: DELAY_LINE_LOAD=1 for one cycle; TAP_CUR←0.
  - SETTLE: SETTLE cycles.
  - STEP_HI: MOVE=1, DIRECTION=1.
  - STEP_LO: MOVE=0. If OUT_OF_RANGE=1, the FSM goes to IDLE, TRIM_ERR pulses and TAP_CUR is unchanged. Otherwise TAP_CUR+=1; if TAP_CUR==target → TRIM_DONE pulses, IDLE; else → STEP_HI.
  - Target 0: SETTLE → IDLE with TRIM_DONE.
  - TRIM_REQ while not IDLE is ignored.
  - DIRECTION is held 1 from LOAD until IDLE, and is 0 in IDLE.
- ODT and trim paths are independent; simultaneous requests are both served.
- Reset mid-operation: the next cycle has all outputs 0, rem=0, FSM IDLE, and no DONE/ERR pulse.

## Timing
- TX_DATA/OE_DATA/ODT_BUSY are registered: request sampled at cycle c → first word at c+1.
- Trim with REQ at c and target T≥1:
  - LOAD at c+1.
  - MOVE at c+SETTLE+2, +2 per step; last MOVE at c+SETTLE+2T.
  - TRIM_DONE at c+SETTLE+2T+1.
- Trim with T=0: TRIM_DONE at c+SETTLE+2.
- MOVE pulse width is 1 cycle, spacing 2 cycles. OUT_OF_RANGE is sampled only in STEP_LO.

## Configuration
- ODT_LANE_TRIM_EN defined: trim FSM built as above.
- ODT_LANE_TRIM_EN undefined: no trim logic is built.
  - DELAY_LINE_LOAD/MOVE/DIRECTION and TAP_CUR tied 0; TRIM_ERR tied 0.
  - TRIM_DONE pulses one cycle after TRIM_REQ.

## Test plan
- GEAR=4, PHASE=1, LEN=6 on ch0 at cycle 5 → TX_DATA[3:0]=4'b1110 at 6, 4'b0111 at 7, 0 at 8; ODT_BUSY high cycles 6–7.
- ODT_REQ on ch0 at cycle 6 during the above burst → ODT_DROP[0] pulse at 7; burst unchanged. LEN=0 request → DROP, no data.
- CH_EN[1] 0→1 sampled at cycle 3 → OE_DATA[7:4]=4'hF from cycle 4; back to 0 one cycle after CH_EN falls.
- SETTLE=4, TRIM_REQ ch1 target 3 at cycle 0 → LOAD at 1, MOVE at 6, 8, 10, TRIM_DONE at 11, TAP_CUR=3. Target 0 → DONE at 6.
- Target 10, OUT_OF_RANGE forced high at cycle 9 → TRIM_ERR at 10, TAP_CUR=1, FSM IDLE, no DONE.
- TX_SYNC_RST at cycle 8 mid-trim and mid-burst → at cycle 9 all outputs 0. A new TRIM_REQ at 10 restarts cleanly (LOAD at 11).

Source files
------------

// File: rtl/ddr3_odt_lane_ctrl.sv
// ddr3_odt_lane_ctrl: per-lane DDR3 ODT burst generator (GEAR-wide TX/OE words) and delay-line trim sequencer.
// The trim sequencer exists only when ODT_LANE_TRIM_EN is defined; otherwise TRIM_DONE echoes TRIM_REQ one cycle later.
module ddr3_odt_lane_ctrl #(
  parameter int NUM_CH = 2,
  parameter int GEAR   = 4,
  parameter int LEN_W  = 6,
  parameter int TAP_W  = 7,
  parameter int SETTLE = 4
) (
  input  logic                           FAB_CLK,
  input  logic                           TX_SYNC_RST,
  input  logic [NUM_CH-1:0]              CH_EN,
  input  logic [NUM_CH-1:0]              ODT_REQ,
  input  logic [NUM_CH*$clog2(GEAR)-1:0] ODT_PHASE,
  input  logic [NUM_CH*LEN_W-1:0]        ODT_LEN,
  output logic [NUM_CH-1:0]              ODT_BUSY,
  output logic [NUM_CH-1:0]              ODT_DROP,
  output logic [NUM_CH*GEAR-1:0]         TX_DATA,
  output logic [NUM_CH*GEAR-1:0]         OE_DATA,
  input  logic [NUM_CH-1:0]              TRIM_REQ,
  input  logic [NUM_CH*TAP_W-1:0]        TRIM_TARGET,
  output logic [NUM_CH-1:0]              TRIM_DONE,
  output logic [NUM_CH-1:0]              TRIM_ERR,
  output logic [NUM_CH*TAP_W-1:0]        TAP_CUR,
  output logic [NUM_CH-1:0]              DELAY_LINE_LOAD,
  output logic [NUM_CH-1:0]              DELAY_LINE_MOVE,
  output logic [NUM_CH-1:0]              DELAY_LINE_DIRECTION,
  input  logic [NUM_CH-1:0]              DELAY_LINE_OUT_OF_RANGE
);

  localparam int PH_W  = $clog2(GEAR);
  localparam int REM_W = LEN_W + 1;
  localparam int CNT_W = $clog2(SETTLE + 1);

`ifdef ODT_LANE_TRIM_EN
  typedef enum logic [2:0] {T_IDLE, T_LOAD, T_SETTLE, T_STEP_HI, T_STEP_LO} trim_state_t;
`else
  logic w_unused_trim;
  assign w_unused_trim = &{1'b0, TRIM_TARGET, DELAY_LINE_OUT_OF_RANGE};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      logic [PH_W-1:0]  w_phase;
      logic [LEN_W-1:0] w_len;
      logic             w_accept;
      logic [GEAR-1:0]  w_word;
      logic [REM_W-1:0] w_rem_next;
      logic [REM_W-1:0] r_rem;
      logic [GEAR-1:0]  r_tx;
      logic [GEAR-1:0]  r_oe;
      logic             r_busy;
      logic             r_drop;

      assign w_phase  = ODT_PHASE[gi*PH_W +: PH_W];
      assign w_len    = ODT_LEN[gi*LEN_W +: LEN_W];
      // r_busy low implies r_rem is 0, so an accepted burst never overlaps a running one
      assign w_accept = ODT_REQ[gi] && !r_busy && (w_len != '0);

      always_comb begin
        w_word     = '0;
        w_rem_next = '0;
        if (w_accept) begin
          for (int s = 0; s < GEAR; s++)
            w_word[s] = (s >= int'(w_phase)) && (s < int'(w_phase) + int'(w_len));
          if (int'(w_len) > GEAR - int'(w_phase))
            w_rem_next = REM_W'(int'(w_len) + int'(w_phase) - GEAR);
        end else begin
          for (int s = 0; s < GEAR; s++)
            w_word[s] = (s < int'(r_rem));
          if (int'(r_rem) > GEAR)
            w_rem_next = REM_W'(int'(r_rem) - GEAR);
        end
      end

      always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
          r_rem  <= '0;
          r_tx   <= '0;
          r_oe   <= '0;
          r_busy <= 1'b0;
          r_drop <= 1'b0;
        end else begin
          r_rem  <= w_rem_next;
          r_tx   <= w_word;
          r_oe   <= {GEAR{CH_EN[gi]}};
          r_busy <= |w_word;
          r_drop <= ODT_REQ[gi] && !w_accept;
        end
      end

      assign TX_DATA[gi*GEAR +: GEAR] = r_tx;
      assign OE_DATA[gi*GEAR +: GEAR] = r_oe;
      assign ODT_BUSY[gi]             = r_busy;
      assign ODT_DROP[gi]             = r_drop;

`ifdef ODT_LANE_TRIM_EN
      trim_state_t      r_state;
      trim_state_t      w_state_next;
      logic [TAP_W-1:0] r_target;
      logic [TAP_W-1:0] r_tap;
      logic [TAP_W:0]   w_tap_inc;
      logic [CNT_W-1:0] r_cnt;
      logic             r_err;
      logic             r_done0;
      logic             w_done;
      logic             w_err_next;
      logic             w_done0_next;
      logic             w_oor;

      assign w_oor     = DELAY_LINE_OUT_OF_RANGE[gi];
      assign w_tap_inc = {1'b0, r_tap} + (TAP_W + 1)'(1);

      always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_err_next   = 1'b0;
        w_done0_next = 1'b0;
        case (r_state)
          T_IDLE:    if (TRIM_REQ[gi]) w_state_next = T_LOAD;
          T_LOAD:    w_state_next = T_SETTLE;
          T_SETTLE: begin
            if (r_cnt == CNT_W'(SETTLE - 1)) begin
              if (r_target == '0) begin
                w_state_next = T_IDLE;
                w_done0_next = 1'b1;
              end else begin
                w_state_next = T_STEP_HI;
              end
            end
          end
          T_STEP_HI: w_state_next = T_STEP_LO;
          // Completion is reported in the final STEP_LO cycle itself; range errors a cycle later
          T_STEP_LO: begin
            if (w_oor) begin
              w_state_next = T_IDLE;
              w_err_next   = 1'b1;
            end else if (w_tap_inc == {1'b0, r_target}) begin
              w_state_next = T_IDLE;
              w_done       = 1'b1;
            end else begin
              w_state_next = T_STEP_HI;
            end
          end
          default:   w_state_next = T_IDLE;
        endcase
      end

      always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
          r_state  <= T_IDLE;
          r_target <= '0;
          r_tap    <= '0;
          r_cnt    <= '0;
          r_err    <= 1'b0;
          r_done0  <= 1'b0;
        end else begin
          r_state <= w_state_next;
          r_err   <= w_err_next;
          r_done0 <= w_done0_next;
          r_cnt   <= (r_state == T_SETTLE) ? r_cnt + CNT_W'(1) : '0;
          if (r_state == T_IDLE && TRIM_REQ[gi])
            r_target <= TRIM_TARGET[gi*TAP_W +: TAP_W];
          if (r_state == T_LOAD)
            r_tap <= '0;
          else if (r_state == T_STEP_LO && !w_oor)
            r_tap <= w_tap_inc[TAP_W-1:0];
        end
      end

      assign TRIM_DONE[gi]            = r_done0 | w_done;
      assign TRIM_ERR[gi]             = r_err;
      assign TAP_CUR[gi*TAP_W +: TAP_W] = r_tap;
      assign DELAY_LINE_LOAD[gi]      = (r_state == T_LOAD);
      assign DELAY_LINE_MOVE[gi]      = (r_state == T_STEP_HI);
      assign DELAY_LINE_DIRECTION[gi] = (r_state != T_IDLE);
`else
      logic r_done;

      always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) r_done <= 1'b0;
        else             r_done <= TRIM_REQ[gi];
      end

      assign TRIM_DONE[gi]              = r_done;
      assign TRIM_ERR[gi]               = 1'b0;
      assign TAP_CUR[gi*TAP_W +: TAP_W] = '0;
      assign DELAY_LINE_LOAD[gi]        = 1'b0;
      assign DELAY_LINE_MOVE[gi]        = 1'b0;
      assign DELAY_LINE_DIRECTION[gi]   = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_ddr3_odt_lane_ctrl.sv
// tb_ddr3_odt_lane_ctrl: directed plus random stimulus checked against a slot-timeline reference model.
// Trim expectations follow the ODT_LANE_TRIM_EN setting the design is built with.
module tb_ddr3_odt_lane_ctrl;
  localparam int NUM_CH = 2;
  localparam int GEAR   = 4;
  localparam int LEN_W  = 6;
  localparam int TAP_W  = 7;
  localparam int SETTLE = 4;
  localparam int PH_W   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     srst;
  logic [NUM_CH-1:0]        ch_en, odt_req, odt_busy, odt_drop;
  logic [NUM_CH-1:0]        trim_req, trim_done, trim_err;
  logic [NUM_CH-1:0]        dl_load, dl_move, dl_dir, dl_oor;
  logic [NUM_CH*PH_W-1:0]   odt_phase;
  logic [NUM_CH*LEN_W-1:0]  odt_len;
  logic [NUM_CH*GEAR-1:0]   tx_data, oe_data;
  logic [NUM_CH*TAP_W-1:0]  trim_target, tap_cur;

  ddr3_odt_lane_ctrl #(
    .NUM_CH(NUM_CH), .GEAR(GEAR), .LEN_W(LEN_W), .TAP_W(TAP_W), .SETTLE(SETTLE)
  ) u_dut (
    .FAB_CLK(clk),
    .TX_SYNC_RST(srst),
    .CH_EN(ch_en),
    .ODT_REQ(odt_req),
    .ODT_PHASE(odt_phase),
    .ODT_LEN(odt_len),
    .ODT_BUSY(odt_busy),
    .ODT_DROP(odt_drop),
    .TX_DATA(tx_data),
    .OE_DATA(oe_data),
    .TRIM_REQ(trim_req),
    .TRIM_TARGET(trim_target),
    .TRIM_DONE(trim_done),
    .TRIM_ERR(trim_err),
    .TAP_CUR(tap_cur),
    .DELAY_LINE_LOAD(dl_load),
    .DELAY_LINE_MOVE(dl_move),
    .DELAY_LINE_DIRECTION(dl_dir),
    .DELAY_LINE_OUT_OF_RANGE(dl_oor)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: each lane's burst is a range of absolute slot indices [b_start, b_end)
  int                b_start[NUM_CH];
  int                b_end[NUM_CH];
  logic [NUM_CH-1:0] m_drop, m_oe_en, m_done_reg, m_err;
  bit                t_act[NUM_CH];
  int                t_c[NUM_CH];
  int                t_T[NUM_CH];
  int                t_tap[NUM_CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [GEAR-1:0] m_word(input int ch, input int n);
    logic [GEAR-1:0] w;
    w = '0;
    for (int s = 0; s < GEAR; s++)
      w[s] = ((n * GEAR + s) >= b_start[ch]) && ((n * GEAR + s) < b_end[ch]);
    return w;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      b_start[ch] = 0;
      b_end[ch]   = 0;
      t_act[ch]   = 0;
      t_c[ch]     = 0;
      t_T[ch]     = 0;
      t_tap[ch]   = 0;
    end
    m_drop = '0; m_oe_en = '0; m_done_reg = '0; m_err = '0;
  endtask

  task automatic check_outputs();
    logic [NUM_CH*GEAR-1:0]  e_tx, e_oe;
    logic [NUM_CH-1:0]       e_busy, e_load, e_move, e_dir, e_done, e_err;
    logic [NUM_CH*TAP_W-1:0] e_tap;
    logic [GEAR-1:0]         w;
    int                      rel;
    e_load = '0; e_move = '0; e_dir = '0; e_err = '0; e_tap = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w = m_word(ch, cyc);
      e_tx[ch*GEAR +: GEAR] = w;
      e_oe[ch*GEAR +: GEAR] = {GEAR{m_oe_en[ch]}};
      e_busy[ch] = |w;
      e_done[ch] = m_done_reg[ch];
`ifdef ODT_LANE_TRIM_EN
      rel = cyc - t_c[ch];
      e_load[ch] = t_act[ch] && (rel == 1);
      e_dir[ch]  = t_act[ch];
      e_move[ch] = t_act[ch] && (rel >= SETTLE + 2) && ((rel - SETTLE) % 2 == 0);
      if (t_act[ch] && t_T[ch] > 0 && rel == SETTLE + 2 * t_T[ch] + 1 && !dl_oor[ch])
        e_done[ch] = 1'b1;
      e_err[ch] = m_err[ch];
      e_tap[ch*TAP_W +: TAP_W] = TAP_W'(t_tap[ch]);
`else
      rel = 0;
`endif
    end
    chk("tx_data", tx_data, e_tx);
    chk("oe_data", oe_data, e_oe);
    chk("odt_busy", odt_busy, e_busy);
    chk("odt_drop", odt_drop, m_drop);
    chk("trim_done", trim_done, e_done);
    chk("trim_err", trim_err, e_err);
    chk("tap_cur", tap_cur, e_tap);
    chk("dl_load", dl_load, e_load);
    chk("dl_move", dl_move, e_move);
    chk("dl_dir", dl_dir, e_dir);
  endtask

  task automatic model_advance();
    int len, ph, rel;
    if (srst) begin
      model_reset();
      return;
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_drop[ch] = 1'b0;
      if (odt_req[ch]) begin
        len = int'(odt_len[ch*LEN_W +: LEN_W]);
        ph  = int'(odt_phase[ch*PH_W +: PH_W]);
        if (m_word(ch, cyc) == '0 && len != 0) begin
          b_start[ch] = (cyc + 1) * GEAR + ph;
          b_end[ch]   = b_start[ch] + len;
          $display("cyc %0d ch%0d odt accept phase=%0d len=%0d", cyc, ch, ph, len);
        end else begin
          m_drop[ch] = 1'b1;
          $display("cyc %0d ch%0d odt ignored phase=%0d len=%0d", cyc, ch, ph, len);
        end
      end
      m_oe_en[ch] = ch_en[ch];
`ifdef ODT_LANE_TRIM_EN
      m_done_reg[ch] = 1'b0;
      m_err[ch]      = 1'b0;
      if (t_act[ch]) begin
        rel = cyc - t_c[ch];
        if (rel == 1) t_tap[ch] = 0;
        if (t_T[ch] == 0 && rel == SETTLE + 1) begin
          t_act[ch] = 0;
          m_done_reg[ch] = 1'b1;
        end else if (rel >= SETTLE + 3 && (rel - SETTLE) % 2 == 1) begin
          if (dl_oor[ch]) begin
            m_err[ch] = 1'b1;
            t_act[ch] = 0;
          end else begin
            t_tap[ch]++;
            if (t_tap[ch] == t_T[ch]) t_act[ch] = 0;
          end
        end
      end else if (trim_req[ch]) begin
        t_act[ch] = 1;
        t_c[ch]   = cyc;
        t_T[ch]   = int'(trim_target[ch*TAP_W +: TAP_W]);
        $display("cyc %0d ch%0d trim start target=%0d", cyc, ch, t_T[ch]);
      end
`else
      rel = 0;
      m_done_reg[ch] = trim_req[ch];
      if (trim_req[ch]) $display("cyc %0d ch%0d trim request (stub)", cyc, ch);
`endif
    end
  endtask

  // Check the current cycle, update the model with the sampled inputs, then advance one clock
  task automatic cycle();
    #1;
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int t0, got;
    srst = 1'b1; ch_en = '0; odt_req = '0; odt_phase = '0; odt_len = '0;
    trim_req = '0; trim_target = '0; dl_oor = '0;
    @(posedge clk);
    #1;
    model_reset();
    cycle();
    cycle();
    srst = 1'b0;
    cycle();

    // OE follows CH_EN with one cycle of latency
    ch_en = 2'b10;
    cycle();
    chk("oe_on_ch1", oe_data[7:4], 4'hF);
    chk("oe_off_ch0", oe_data[3:0], 4'h0);
    ch_en = 2'b00;
    cycle();
    chk("oe_fall_ch1", oe_data[7:4], 4'h0);

    // PHASE=1, LEN=6 burst, overlapping request dropped, LEN=0 dropped
    odt_req = 2'b01; odt_phase[1:0] = 2'd1; odt_len[5:0] = 6'd6;
    cycle();
    chk("burst_w0", tx_data[3:0], 4'b1110);
    chk("burst_busy0", odt_busy[0], 1'b1);
    cycle();
    odt_req = 2'b00;
    chk("burst_w1", tx_data[3:0], 4'b0111);
    chk("burst_drop", odt_drop[0], 1'b1);
    cycle();
    chk("burst_end", tx_data[3:0], 4'b0000);
    chk("burst_busy_end", odt_busy[0], 1'b0);
    odt_req = 2'b01; odt_len[5:0] = 6'd0;
    cycle();
    odt_req = 2'b00;
    chk("len0_drop", odt_drop[0], 1'b1);
    chk("len0_nodata", tx_data[3:0], 4'b0000);
    odt_req = 2'b10; odt_phase[3:2] = 2'd3; odt_len[11:6] = 6'd9;
    cycle();
    odt_req = 2'b00;
    chk("ph3_w0", tx_data[7:4], 4'b1000);
    repeat (4) cycle();

    // Trim ch1 to tap 3
    t0 = cyc;
    trim_req = 2'b10; trim_target[13:7] = 7'd3;
    cycle();
    trim_req = '0;
`ifdef ODT_LANE_TRIM_EN
    got = -1;
    for (int k = 0; k < 40 && got < 0; k++) begin
      if (trim_done[1] === 1'b1) got = cyc - t0;
      else cycle();
    end
    chk("trim3_done_lat", got, SETTLE + 2 * 3 + 1);
    cycle();
    chk("trim3_tap", tap_cur[13:7], 7'd3);

    // Target 10 with OUT_OF_RANGE raised at relative cycle 9
    t0 = cyc;
    trim_req = 2'b01; trim_target[6:0] = 7'd10;
    cycle();
    trim_req = '0;
    while (cyc < t0 + 9) cycle();
    dl_oor = 2'b01;
    cycle();
    dl_oor = '0;
    chk("oor_err", trim_err[0], 1'b1);
    chk("oor_tap", tap_cur[6:0], 7'd1);
    chk("oor_idle_dir", dl_dir[0], 1'b0);
`else
    got = 0;
    chk("trim_stub_done", trim_done[1], 1'b1);
    chk("trim_stub_tap", tap_cur, '0);
`endif
    repeat (3) cycle();

    // Reset in the middle of a burst and a trim
    ch_en = 2'b11;
    odt_req = 2'b01; odt_phase[1:0] = 2'd0; odt_len[5:0] = 6'd20;
    trim_req = 2'b10; trim_target[13:7] = 7'd5;
    cycle();
    odt_req = '0; trim_req = '0;
    repeat (3) cycle();
    srst = 1'b1;
    cycle();
    srst = 1'b0; ch_en = '0;
    chk("rst_tx", tx_data, '0);
    chk("rst_oe", oe_data, '0);
    chk("rst_busy", odt_busy, '0);
    chk("rst_done", trim_done, '0);
    chk("rst_dir", dl_dir, '0);
    trim_req = 2'b10; trim_target[13:7] = 7'd2;
    cycle();
    trim_req = '0;
`ifdef ODT_LANE_TRIM_EN
    chk("restart_load", dl_load[1], 1'b1);
`else
    chk("restart_done", trim_done[1], 1'b1);
`endif
    repeat (20) cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      srst        = ($urandom_range(0, 79) == 0);
      odt_req     = NUM_CH'($urandom_range(0, 3) & $urandom_range(0, 3));
      odt_phase   = NUM_CH*PH_W'($urandom);
      odt_len     = {6'($urandom_range(0, 20)), 6'($urandom_range(0, 20))};
      trim_req    = NUM_CH'($urandom_range(0, 3) & $urandom_range(0, 3) & $urandom_range(0, 3));
      trim_target = {7'($urandom_range(0, 5)), 7'($urandom_range(0, 5))};
      dl_oor      = NUM_CH'(($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0);
      if ($urandom_range(0, 7) == 0) ch_en = NUM_CH'($urandom);
      cycle();
    end
    srst = 1'b0; odt_req = '0; trim_req = '0; dl_oor = '0; ch_en = '0;
    repeat (40) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
